conv_fifo_out: RTL and testbench
================================

CONV_FIFO_OUT -- requirements
Module: conv_fifo_out

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of products and results.
REQ-002 SHALL have parameter KSIZE, default 3, products summed per output sample.
REQ-003 SHALL have parameter DEPTH, default 8, result FIFO entries (power of two).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 prod_in  input  DATA_W  one product term from the multiplier stage.
REQ-007 prod_valid  input  1  prod_in is valid this cycle.
REQ-008 en  output  1  ready to upstream; a product is accepted when prod_valid && en.
REQ-009 data_out  output  DATA_W  head-of-FIFO result (show-ahead).
REQ-010 data_valid  output  1  data_out holds a valid result.
REQ-011 data_ready  input  1  consumer takes data_out when data_valid && data_ready.
REQ-012 count  output  clog2(DEPTH)+1  number of stored results, 0..DEPTH.
REQ-013 full / empty  output  1 each  count==DEPTH / count==0.
REQ-014 drop  output  1  sticky flag: prod_valid seen while en==0.

Function
REQ-015 Tap counter 0..KSIZE-1 SHALL advance by one per accepted product and wrap from KSIZE-1 to 0.
REQ-016 On an accepted product at tap 0, the accumulator SHALL load prod_in; at later taps it SHALL add prod_in, modulo 2^DATA_W (carry discarded).
REQ-017 On an accepted product at tap KSIZE-1, the sum (accumulator + prod_in) SHALL be written to FIFO[w_pt] at that edge, w_pt SHALL increment, and the accumulator SHALL clear.
REQ-018 Latency: data_valid SHALL be high in the cycle after the edge that accepted the final tap, if the FIFO was empty.
REQ-019 en SHALL equal !full, decoded from registered state only (no combinational path from prod_valid or data_ready).
REQ-020 data_out SHALL be FIFO[r_pt]; data_valid SHALL equal !empty; a pop increments r_pt.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0; count SHALL track pushes minus pops.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and both pointers advanced.
REQ-023 When full, no product SHALL be accepted (tap and accumulator hold); a pop in that cycle does not enable acceptance until the next cycle.
REQ-024 Pop when empty SHALL be ignored; data_out is don't-care while data_valid==0.
REQ-025 prod_valid while en==0 SHALL set drop, leave tap/accumulator/FIFO unchanged; drop stays set until reset.
REQ-026 Results SHALL leave in the order their final taps were accepted.

Reset
REQ-027 On reset: tap=0, accumulator=0, w_pt=r_pt=0, count=0, drop=0, so en=1, empty=1, full=0, data_valid=0, data_out=0.
REQ-028 Reset mid-group SHALL discard the partial sum and all stored results; FIFO contents need not be cleared.
REQ-029 reset SHALL take priority over any simultaneous accept or pop.

Structure
REQ-030 Package conv_pkg SHALL hold DATA_W=32, KSIZE=3, FIFO_DEPTH=8, shared with the input-side FIFO and MAC.
REQ-031 One sub-module conv_acc SHALL hold tap counter and accumulator, outputting sum and a last-tap strobe; FIFO storage and pointers stay in conv_fifo_out.

Verification
REQ-032 Reset, idle -> en=1, empty=1, data_valid=0, count=0, drop=0, data_out=0.
REQ-033 data_ready=1; products 1,2,3,4,5,6 on consecutive cycles -> data_out 6 then 15, each valid the cycle after its third tap.
REQ-034 data_ready=0; 24 products of value 1 -> count=8, full=1, en=0; 25th valid -> drop=1, count stays 8; then data_ready=1 -> eight 3s, empty=1, en=1.
REQ-035 Products 0xFFFFFFFF,1,1 -> data_out=0x00000001 (wrap-around).
REQ-036 count=4, push and pop on the same edge -> count=4, order preserved.
REQ-037 Products 5,5 then reset, then 7,8,9 -> single result 24, count=1, drop=0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and depths for the convolution datapath (input FIFO, MAC, output FIFO).
package conv_pkg;
   localparam int DATA_W     = 32;
   localparam int KSIZE      = 3;
   localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/conv_acc.sv
// conv_acc: tap counter and running accumulator; sum/last are combinational views of the current accept.
module conv_acc import conv_pkg::*; #(
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int KSIZE  = conv_pkg::KSIZE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] prod_in,
   input  logic              accept,
   output logic [DATA_W-1:0] sum,
   output logic              last
);
   localparam int TW = KSIZE > 1 ? $clog2(KSIZE) : 1;
   logic [TW-1:0]     tap;
   logic [DATA_W-1:0] acc;
   // tap 0 loads rather than adds, so a stale accumulator can never leak into a new group
   always_comb begin
      last = tap == TW'(KSIZE - 1);
      sum  = (tap == '0 ? '0 : acc) + prod_in;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tap <= '0;
         acc <= '0;
      end else if (accept) begin
         tap <= last ? '0 : tap + TW'(1);
         acc <= last ? '0 : sum;
      end
   end
endmodule

// File: rtl/conv_fifo_out.sv
// conv_fifo_out: sums KSIZE product terms per output sample and queues results in a show-ahead FIFO.
module conv_fifo_out import conv_pkg::*; #(
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int KSIZE  = conv_pkg::KSIZE,
   parameter int DEPTH  = conv_pkg::FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        prod_in,
   input  logic                     prod_valid,
   output logic                     en,
   output logic [DATA_W-1:0]        data_out,
   output logic                     data_valid,
   input  logic                     data_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     w_pt, r_pt;
   logic [DATA_W-1:0] sum;
   logic              last, accept, push, pop;
   // en/full/empty decode only from count, so a pop never opens acceptance in the same cycle
   always_comb begin
      full       = count == CW'(DEPTH);
      empty      = count == '0;
      en         = !full;
      data_valid = !empty;
      data_out   = empty ? '0 : mem[r_pt];
      accept     = prod_valid && en;
      push       = accept && last;
      pop        = data_valid && data_ready;
   end
   conv_acc #(.DATA_W(DATA_W), .KSIZE(KSIZE)) u_acc (
      .clk(clk), .reset(reset), .prod_in(prod_in), .accept(accept), .sum(sum), .last(last)
   );
   always_ff @(posedge clk) begin
      if (!reset && push) mem[w_pt] <= sum;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         w_pt  <= '0;
         r_pt  <= '0;
         count <= '0;
         drop  <= 1'b0;
      end else begin
         if (push) w_pt <= w_pt + PW'(1);
         if (pop) r_pt <= r_pt + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (prod_valid && !en) drop <= 1'b1;
      end
   end
endmodule

// File: tb/tb_conv_fifo_out.sv
// tb_conv_fifo_out: directed vectors with hand-computed results for conv_fifo_out.
module tb_conv_fifo_out;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] prod_in = '0;
   logic        prod_valid = 1'b0;
   logic        en;
   logic [31:0] data_out;
   logic        data_valid;
   logic        data_ready = 1'b0;
   logic [3:0]  count;
   logic        full, empty, drop;
   int          checks = 0;
   int          failures = 0;

   conv_fifo_out dut (
      .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid), .en(en),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .count(count), .full(full), .empty(empty), .drop(drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] v);
      prod_in = v;
      prod_valid = 1'b1;
      step();
      prod_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      prod_valid = 1'b0;
      data_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_q [4];
      do_reset();
      step();
      chk("rst_en", 32'(en), 1);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_valid", 32'(data_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_drop", 32'(drop), 0);
      chk("rst_dout", data_out, 0);

      data_ready = 1'b1;
      put(1);
      chk("seq_nv1", 32'(data_valid), 0);
      put(2);
      chk("seq_nv2", 32'(data_valid), 0);
      put(3);
      chk("seq_v6", 32'(data_valid), 1);
      chk("seq_d6", data_out, 6);
      put(4);
      chk("seq_pop6", 32'(data_valid), 0);
      put(5);
      put(6);
      chk("seq_v15", 32'(data_valid), 1);
      chk("seq_d15", data_out, 15);
      step();
      chk("seq_empty", 32'(empty), 1);

      data_ready = 1'b0;
      for (int i = 0; i < 24; i++) put(1);
      chk("fill_count", 32'(count), 8);
      chk("fill_full", 32'(full), 1);
      chk("fill_en", 32'(en), 0);
      chk("fill_drop0", 32'(drop), 0);
      put(1);
      chk("over_drop", 32'(drop), 1);
      chk("over_count", 32'(count), 8);
      data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_v%0d", i), 32'(data_valid), 1);
         chk($sformatf("drain_d%0d", i), data_out, 3);
         step();
      end
      chk("drain_empty", 32'(empty), 1);
      chk("drain_en", 32'(en), 1);
      chk("drain_drop", 32'(drop), 1);
      data_ready = 1'b0;

      do_reset();
      chk("clr_drop", 32'(drop), 0);
      put(32'hFFFF_FFFF);
      put(1);
      put(1);
      chk("wrap_d", data_out, 1);
      chk("wrap_count", 32'(count), 1);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      chk("wrap_empty", 32'(empty), 1);

      for (int i = 1; i <= 14; i++) put(32'(i));
      chk("pp_count4", 32'(count), 4);
      chk("pp_head6", data_out, 6);
      data_ready = 1'b1;
      put(15);
      data_ready = 1'b0;
      chk("pp_count", 32'(count), 4);
      chk("pp_head15", data_out, 15);
      exp_q = '{15, 24, 33, 42};
      data_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pp_order%0d", i), data_out, exp_q[i]);
         step();
      end
      chk("pp_empty", 32'(empty), 1);
      data_ready = 1'b0;

      put(5);
      put(5);
      do_reset();
      put(7);
      put(8);
      put(9);
      chk("mid_count", 32'(count), 1);
      chk("mid_d", data_out, 24);
      chk("mid_drop", 32'(drop), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
